xadac_axi_rd_fetch: RTL and testbench
=====================================

Name: xadac_axi_rd_fetch

Overview:
- Read-fetch master that turns a simple descriptor (base address, beat count) into legal AXI4 INCR read bursts.
- Returns the read data as a valid/ready stream in request order.
- Sits directly upstream of the AXI register-slice stage: its AXI_BUS.Master port feeds that cut's slave side, and that cut then drives the memory fabric.
- Handles burst splitting at MaxBurstLen and at 4 KiB boundaries, caps outstanding bursts, and marks the final beat and any error response.

Parameters:
- IdWidth, 4, AXI ID width.
- AddrWidth, 64, AXI address width.
- DataWidth, 64, AXI data width; power of two, at least 8.
- UserWidth, 1, AXI user width.
- LenWidth, 16, width of the descriptor beat count.
- MaxBurstLen, 16, maximum beats per AR burst; range 1..256.
- MaxOutstanding, 4, maximum AR bursts whose R last has not yet been received.
- AxId, 0, constant value driven on ar_id.

Ports:
- clk  in  1  clock; every register is rising-edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  descriptor valid.
- req_ready  out  1  descriptor accepted when req_valid && req_ready.
- req_addr  in  AddrWidth  start byte address; low log2(DataWidth/8) bits are ignored (forced 0).
- req_beats  in  LenWidth  number of data beats to fetch.
- data_valid  out  1  read beat valid.
- data_ready  in  1  consumer ready.
- data  out  DataWidth  read data (r_data).
- data_last  out  1  final beat of the whole descriptor.
- err  out  1  sticky: some beat of the current descriptor had r_resp != OKAY.
- busy  out  1  high whenever state != IDLE.
- mst  AXI_BUS.Master  -  AXI4 master port; only the AR and R channels are used.

Behaviour:
- Interface decision: one clock; reset is synchronous and active-high.
- Reset values:
  - req_ready=0 during rst, then 1 in IDLE.
  - busy=0, err=0, ar_valid=0, data_valid follows r_valid gated by state (0 in IDLE).
  - All counters are 0.
- Unused AXI channels: aw_valid=0, w_valid=0, b_ready=1.
- AR field constants:
  - ar_size=log2(DataWidth/8), ar_burst=INCR.
  - ar_lock, ar_cache, ar_prot, ar_qos, ar_region, ar_atop, ar_user all 0.
  - ar_id=AxId.
- State machine IDLE / ISSUE / DRAIN:
  - IDLE: req_ready=1. On accept, latch the aligned address into cur_addr and req_beats into ar_rem and rx_rem, and clear err.
    - If req_beats==0: stay in IDLE, issue no AXI traffic, produce no data beat.
    - Otherwise go to ISSUE.
  - ISSUE: registered AR generation.
    - n = min(ar_rem, MaxBurstLen, (4096 - cur_addr[11:0]) / (DataWidth/8)).
    - ar_addr=cur_addr, ar_len=n-1.
    - ar_valid rises only when outstanding < MaxOutstanding.
    - Once raised, ar_valid and all AR fields stay stable until ar_ready.
    - On handshake: cur_addr += n*(DataWidth/8), ar_rem -= n, outstanding++.
    - When ar_rem reaches 0 after a handshake, go to DRAIN.
  - DRAIN: wait until rx_rem==0 and outstanding==0, then go to IDLE.
- R path, combinational pass-through in ISSUE and DRAIN:
  - data_valid=r_valid, r_ready=data_ready, data=r_data.
  - data_last = r_valid && rx_rem==1.
  - On each R handshake, rx_rem--.
  - On an R handshake with r_last, outstanding--.
- R beats can arrive while still in ISSUE; this is legal and required to work.
- An AR handshake and an r_last handshake in the same cycle leave outstanding unchanged.
- err:
  - Set on any R handshake with r_resp[1]==1 (SLVERR/DECERR).
  - Held until the next descriptor accept.
  - Data beats are still delivered, and the beat count is unchanged.
- 4 KiB rule: no burst crosses a 4 KiB boundary. A burst ending exactly on the boundary is legal.
- Counter widths:
  - outstanding: clog2(MaxOutstanding+1).
  - ar_rem and rx_rem: LenWidth.
  - cur_addr wraps modulo 2^AddrWidth; no error is flagged on wrap.
- Reset mid-operation:
  - All state returns to IDLE and counters clear next cycle, including a pending ar_valid.
  - This is legal only with a fabric-wide reset.
  - Late R beats after reset are sunk with r_ready=0; they are not consumed.
- Latency: the first ar_valid is asserted in the cycle after descriptor accept.

Test Plan:
- DataWidth=64, req_addr=0x1000, req_beats=4, slave always ready.
  -> one AR: addr 0x1000, len 3, size 3.
  -> 4 data beats, data_last on the 4th only.
  -> busy returns low, req_ready=1.
- req_addr=0x0FF0, req_beats=8.
  -> AR#1 addr 0x0FF0 len 1.
  -> AR#2 addr 0x1000 len 5.
  -> 8 beats total, a single data_last.
- req_beats=40, MaxBurstLen=16, addr 0x0.
  -> AR lens 15, 15, 7 at addrs 0x0, 0x80, 0x100.
- MaxOutstanding=2, slave accepts ARs but withholds R.
  -> exactly 2 ARs issued, ar_valid stays 0.
  -> the third AR appears the cycle after the first r_last handshake.
- R beat 2 of 4 returns SLVERR.
  -> err=1 from the following cycle, all 4 beats still delivered.
  -> err stays 1 in IDLE and clears on the next accept.
- data_ready held 0 for 10 cycles mid-burst.
  -> r_ready=0 throughout, no beats lost or duplicated.
- Assert rst during DRAIN.
  -> next cycle: busy=0, ar_valid=0, req_ready=1, err=0.

Source files
------------

// File: rtl/xadac_axi_rd_fetch_if.sv
// AXI4 bus bundle shared by the read-fetch master and its downstream register slice.
// Master/Slave modports mirror each other; the fetch master only exercises AR and R.
interface AXI_BUS #(
  parameter int unsigned AXI_ADDR_WIDTH = 64,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned AXI_USER_WIDTH = 1
);
  localparam int unsigned StrbWidth = AXI_DATA_WIDTH / 8;

  logic [AXI_ID_WIDTH-1:0]   aw_id;
  logic [AXI_ADDR_WIDTH-1:0] aw_addr;
  logic [7:0]                aw_len;
  logic [2:0]                aw_size;
  logic [1:0]                aw_burst;
  logic                      aw_lock;
  logic [3:0]                aw_cache;
  logic [2:0]                aw_prot;
  logic [3:0]                aw_qos;
  logic [3:0]                aw_region;
  logic [5:0]                aw_atop;
  logic [AXI_USER_WIDTH-1:0] aw_user;
  logic                      aw_valid;
  logic                      aw_ready;

  logic [AXI_DATA_WIDTH-1:0] w_data;
  logic [StrbWidth-1:0]      w_strb;
  logic                      w_last;
  logic [AXI_USER_WIDTH-1:0] w_user;
  logic                      w_valid;
  logic                      w_ready;

  logic [AXI_ID_WIDTH-1:0]   b_id;
  logic [1:0]                b_resp;
  logic [AXI_USER_WIDTH-1:0] b_user;
  logic                      b_valid;
  logic                      b_ready;

  logic [AXI_ID_WIDTH-1:0]   ar_id;
  logic [AXI_ADDR_WIDTH-1:0] ar_addr;
  logic [7:0]                ar_len;
  logic [2:0]                ar_size;
  logic [1:0]                ar_burst;
  logic                      ar_lock;
  logic [3:0]                ar_cache;
  logic [2:0]                ar_prot;
  logic [3:0]                ar_qos;
  logic [3:0]                ar_region;
  logic [5:0]                ar_atop;
  logic [AXI_USER_WIDTH-1:0] ar_user;
  logic                      ar_valid;
  logic                      ar_ready;

  logic [AXI_ID_WIDTH-1:0]   r_id;
  logic [AXI_DATA_WIDTH-1:0] r_data;
  logic [1:0]                r_resp;
  logic                      r_last;
  logic [AXI_USER_WIDTH-1:0] r_user;
  logic                      r_valid;
  logic                      r_ready;

  modport Master (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    input  aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid,
    input  w_ready,
    input  b_id, b_resp, b_user, b_valid,
    output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_atop, ar_user, ar_valid,
    input  ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid,
    output r_ready
  );

  modport Slave (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
           aw_qos, aw_region, aw_atop, aw_user, aw_valid,
    output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid,
    output w_ready,
    output b_id, b_resp, b_user, b_valid,
    input  b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
           ar_qos, ar_region, ar_atop, ar_user, ar_valid,
    output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid,
    input  r_ready
  );
endinterface

// File: rtl/xadac_axi_rd_fetch.sv
// Descriptor-driven AXI4 read master: splits (addr, beats) into INCR bursts that respect
// MaxBurstLen and 4 KiB pages, and streams R data back in order with last/err marking.
module xadac_axi_rd_fetch #(
  parameter int unsigned IdWidth        = 4,
  parameter int unsigned AddrWidth      = 64,
  parameter int unsigned DataWidth      = 64,
  parameter int unsigned UserWidth      = 1,
  parameter int unsigned LenWidth       = 16,
  parameter int unsigned MaxBurstLen    = 16,
  parameter int unsigned MaxOutstanding = 4,
  parameter logic [IdWidth-1:0] AxId    = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [AddrWidth-1:0] req_addr,
  input  logic [LenWidth-1:0]  req_beats,
  output logic                 data_valid,
  input  logic                 data_ready,
  output logic [DataWidth-1:0] data,
  output logic                 data_last,
  output logic                 err,
  output logic                 busy,
  output logic [1:0]           dbg_state,
  AXI_BUS.Master               mst
);
  localparam int unsigned BeatBytes = DataWidth / 8;
  localparam int unsigned SizeLog   = $clog2(BeatBytes);
  localparam int unsigned OutW      = $clog2(MaxOutstanding + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [AddrWidth-1:0] cur_addr_q, cur_addr_d;
  logic [LenWidth-1:0]  ar_rem_q, ar_rem_d;
  logic [LenWidth-1:0]  rx_rem_q, rx_rem_d;
  logic [OutW-1:0]      out_q, out_d;
  logic                 err_q, err_d;
  logic                 ar_valid_q, ar_valid_d;
  logic [AddrWidth-1:0] ar_addr_q, ar_addr_d;
  logic [7:0]           ar_len_q, ar_len_d;
  logic [12:0]          n_q, n_d;

  logic                 active, accept, ar_hs, r_hs, rlast_hs, load;
  logic [AddrWidth-1:0] aligned_addr, base_addr;
  logic [LenWidth-1:0]  base_rem;
  logic [12:0]          to4k, n_next;

  // valid/ready: a transfer happens on any rising edge where both are high; once ar_valid
  // is raised it and every AR field hold until ar_ready. R is a pure pass-through.
  assign active       = (state_q != ST_IDLE);
  assign req_ready    = (state_q == ST_IDLE) && !rst;
  assign accept       = req_valid && req_ready;
  assign ar_hs        = ar_valid_q && mst.ar_ready;
  assign r_hs         = active && mst.r_valid && data_ready;
  assign rlast_hs     = r_hs && mst.r_last;
  assign aligned_addr = req_addr & ~(AddrWidth'(BeatBytes - 1));
  assign out_d        = out_q + OutW'(ar_hs) - OutW'(rlast_hs);

  // The next burst is sized from the address/remainder that will be current after this edge,
  // so a new AR can be loaded in the same cycle as the accept or the previous AR handshake.
  always_comb begin
    base_addr = cur_addr_q;
    base_rem  = ar_rem_q;
    if (state_q == ST_IDLE) begin
      base_addr = aligned_addr;
      base_rem  = req_beats;
    end else if (ar_hs) begin
      base_addr = cur_addr_q + (AddrWidth'(n_q) << SizeLog);
      base_rem  = ar_rem_q - LenWidth'(n_q);
    end
  end

  assign to4k = (13'd4096 - {1'b0, base_addr[11:0]}) >> SizeLog;

  always_comb begin
    n_next = to4k;
    if (32'(n_next) > MaxBurstLen) n_next = 13'(MaxBurstLen);
    if (32'(base_rem) < 32'(n_next)) n_next = 13'(base_rem);
  end

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    ar_rem_d   = ar_rem_q;
    rx_rem_d   = rx_rem_q;
    err_d      = err_q;
    ar_valid_d = ar_valid_q;
    ar_addr_d  = ar_addr_q;
    ar_len_d   = ar_len_q;
    n_d        = n_q;
    load       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          err_d      = 1'b0;
          cur_addr_d = base_addr;
          ar_rem_d   = base_rem;
          rx_rem_d   = req_beats;
          if (req_beats != '0) begin
            state_d = ST_ISSUE;
            load    = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (ar_hs) begin
          ar_valid_d = 1'b0;
          cur_addr_d = base_addr;
          ar_rem_d   = base_rem;
          if (base_rem == '0) state_d = ST_DRAIN;
        end
        if ((!ar_valid_q || ar_hs) && (base_rem != '0) && (out_d < OutW'(MaxOutstanding))) begin
          load = 1'b1;
        end
      end
      ST_DRAIN: begin
        if ((rx_rem_q == '0) && (out_q == '0)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (load) begin
      ar_valid_d = 1'b1;
      ar_addr_d  = base_addr;
      ar_len_d   = 8'(n_next - 13'd1);
      n_d        = n_next;
    end
    if (r_hs) begin
      rx_rem_d = rx_rem_q - LenWidth'(1);
      if (mst.r_resp[1]) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      ar_rem_q   <= '0;
      rx_rem_q   <= '0;
      out_q      <= '0;
      err_q      <= 1'b0;
      ar_valid_q <= 1'b0;
      ar_addr_q  <= '0;
      ar_len_q   <= '0;
      n_q        <= '0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      ar_rem_q   <= ar_rem_d;
      rx_rem_q   <= rx_rem_d;
      out_q      <= out_d;
      err_q      <= err_d;
      ar_valid_q <= ar_valid_d;
      ar_addr_q  <= ar_addr_d;
      ar_len_q   <= ar_len_d;
      n_q        <= n_d;
    end
  end

  assign data_valid = active && mst.r_valid;
  assign data       = mst.r_data;
  assign data_last  = data_valid && (rx_rem_q == LenWidth'(1));
  assign err        = err_q;
  assign busy       = active;
  assign dbg_state  = state_q;

  assign mst.ar_id     = AxId;
  assign mst.ar_addr   = ar_addr_q;
  assign mst.ar_len    = ar_len_q;
  assign mst.ar_size   = 3'(SizeLog);
  assign mst.ar_burst  = 2'b01;
  assign mst.ar_lock   = 1'b0;
  assign mst.ar_cache  = '0;
  assign mst.ar_prot   = '0;
  assign mst.ar_qos    = '0;
  assign mst.ar_region = '0;
  assign mst.ar_atop   = '0;
  assign mst.ar_user   = '0;
  assign mst.ar_valid  = ar_valid_q;
  assign mst.r_ready   = active && data_ready;

  // Write side is tied off: never requests, always drains a stray B.
  assign mst.aw_id     = '0;
  assign mst.aw_addr   = '0;
  assign mst.aw_len    = '0;
  assign mst.aw_size   = '0;
  assign mst.aw_burst  = '0;
  assign mst.aw_lock   = 1'b0;
  assign mst.aw_cache  = '0;
  assign mst.aw_prot   = '0;
  assign mst.aw_qos    = '0;
  assign mst.aw_region = '0;
  assign mst.aw_atop   = '0;
  assign mst.aw_user   = '0;
  assign mst.aw_valid  = 1'b0;
  assign mst.w_data    = '0;
  assign mst.w_strb    = '0;
  assign mst.w_last    = 1'b0;
  assign mst.w_user    = '0;
  assign mst.w_valid   = 1'b0;
  assign mst.b_ready   = 1'b1;

  logic unused_sigs;
  assign unused_sigs = ^{mst.aw_ready, mst.w_ready, mst.b_id, mst.b_resp, mst.b_user,
                         mst.b_valid, mst.r_id, mst.r_resp[0], mst.r_user};
endmodule

// File: tb/tb_xadac_axi_rd_fetch.sv
// Bench for xadac_axi_rd_fetch: a reactive AR/R slave model plus scoreboards for the
// issued bursts and the returned data stream.
module tb_xadac_axi_rd_fetch;
  logic        clk, rst;
  logic        req_valid, req_ready;
  logic [63:0] req_addr;
  logic [15:0] req_beats;
  logic        data_valid, data_ready, data_last, err, busy;
  logic [63:0] data;
  logic [1:0]  dbg_state;

  AXI_BUS #(.AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(4), .AXI_USER_WIDTH(1)) axi ();

  xadac_axi_rd_fetch #(.MaxOutstanding(2)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_beats(req_beats), .data_valid(data_valid),
    .data_ready(data_ready), .data(data), .data_last(data_last), .err(err),
    .busy(busy), .dbg_state(dbg_state), .mst(axi)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  logic [64:0] exp_q[$];
  logic [71:0] exp_ar_q[$];
  logic [63:0] rq_addr[$];
  int          rq_len[$];

  logic        drv_rst = 1'b1, drv_req_valid = 1'b0;
  logic [63:0] drv_req_addr = '0;
  logic [15:0] drv_req_beats = '0;
  int dr_mode = 0, ar_mode = 0;
  logic r_en = 1'b1;
  int r_idx = 0, r_gbeat = 0, err_at = -1;
  int ar_count = 0, data_count = 0;
  logic accepted_now, rlast_now, errbeat_now;

  localparam logic [34:0] AR_ATTR = {3'd3, 2'b01, 4'd0, 1'b0, 4'd0, 3'd0, 4'd0, 4'd0, 6'd0, 1'b0};

  function automatic logic [63:0] mk_data(input logic [63:0] a);
    return {a[31:0] ^ 32'h5A5A_A5A5, a[31:0] ^ 32'h0F0F_1234};
  endfunction

  task automatic step();
    logic [71:0] e;
    logic [64:0] d;
    @(negedge clk);
    rst       = drv_rst;
    req_valid = drv_req_valid;
    req_addr  = drv_req_addr;
    req_beats = drv_req_beats;
    axi.ar_ready = (ar_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
    case (dr_mode)
      0:       data_ready = 1'b1;
      1:       data_ready = ($urandom_range(0, 3) != 0);
      default: data_ready = 1'b0;
    endcase
    if (r_en && rq_len.size() > 0) begin
      axi.r_valid = 1'b1;
      axi.r_data  = mk_data(rq_addr[0] + 64'(8 * r_idx));
      axi.r_last  = (r_idx == rq_len[0] - 1);
      axi.r_resp  = (r_gbeat == err_at) ? 2'b10 : 2'b00;
    end else begin
      axi.r_valid = 1'b0;
      axi.r_data  = '0;
      axi.r_last  = 1'b0;
      axi.r_resp  = 2'b00;
    end
    #1;
    accepted_now = req_valid && req_ready;
    rlast_now    = 1'b0;
    errbeat_now  = 1'b0;
    if (axi.ar_valid && axi.ar_ready) begin
      ar_count++;
      vectors++;
      if (exp_ar_q.size() == 0) begin
        miscompares++;
        $display("FAIL ar_extra: got addr %h len %0d, required no AR", axi.ar_addr, axi.ar_len);
      end else begin
        e = exp_ar_q.pop_front();
        if ({axi.ar_addr, axi.ar_len} !== e) begin
          miscompares++;
          $display("FAIL ar_burst: got addr %h len %0d, required addr %h len %0d",
                   axi.ar_addr, axi.ar_len, e[71:8], e[7:0]);
        end
      end
      vectors++;
      if ({axi.ar_size, axi.ar_burst, axi.ar_id, axi.ar_lock, axi.ar_cache, axi.ar_prot,
           axi.ar_qos, axi.ar_region, axi.ar_atop, axi.ar_user} !== AR_ATTR) begin
        miscompares++;
        $display("FAIL ar_attr: got size %0d burst %0d id %0d, required size 3 burst 1 id 0",
                 axi.ar_size, axi.ar_burst, axi.ar_id);
      end
      rq_addr.push_back(axi.ar_addr);
      rq_len.push_back(int'(axi.ar_len) + 1);
    end
    if (data_valid && data_ready) begin
      data_count++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL data_extra: got %h last %b, required no beat", data, data_last);
      end else begin
        d = exp_q.pop_front();
        if ({data, data_last} !== d) begin
          miscompares++;
          $display("FAIL data_beat: got %h last %b, required %h last %b",
                   data, data_last, d[64:1], d[0]);
        end
      end
    end
    if (axi.r_valid && axi.r_ready) begin
      if (axi.r_resp[1]) errbeat_now = 1'b1;
      if (axi.r_last) rlast_now = 1'b1;
      r_gbeat++;
      r_idx++;
      if (r_idx == rq_len[0]) begin
        r_idx = 0;
        void'(rq_addr.pop_front());
        void'(rq_len.pop_front());
      end
    end
  endtask

  task automatic push_data(input logic [63:0] addr, input int beats);
    logic [63:0] a;
    a = addr & ~64'h7;
    for (int i = 0; i < beats; i++) exp_q.push_back({mk_data(a + 64'(8 * i)), i == beats - 1});
  endtask

  task automatic push_model_ars(input logic [63:0] addr, input int beats);
    logic [63:0] a;
    int rem, n, to4k;
    a = addr & ~64'h7;
    rem = beats;
    while (rem > 0) begin
      to4k = (4096 - int'(a[11:0])) / 8;
      n = rem;
      if (n > 16) n = 16;
      if (n > to4k) n = to4k;
      exp_ar_q.push_back({a, 8'(n - 1)});
      a = a + 64'(n * 8);
      rem -= n;
    end
  endtask

  task automatic start_desc(input logic [63:0] addr, input int beats);
    logic got;
    got = 1'b0;
    ar_count = 0;
    push_data(addr, beats);
    drv_req_valid = 1'b1;
    drv_req_addr  = addr;
    drv_req_beats = 16'(beats);
    for (int i = 0; i < 50 && !got; i++) begin
      step();
      got = accepted_now;
    end
    drv_req_valid = 1'b0;
    vectors++;
    if (!got) begin
      miscompares++;
      $display("FAIL accept_timeout: got no accept, required accept within 50 cycles");
    end
    step();
    vectors++;
    if (axi.ar_valid !== (beats != 0)) begin
      miscompares++;
      $display("FAIL ar_latency: got ar_valid %b, required %b", axi.ar_valid, beats != 0);
    end
  endtask

  task automatic finish_desc();
    int i;
    i = 0;
    while ((exp_q.size() != 0 || exp_ar_q.size() != 0 || busy) && i < 3000) begin
      step();
      i++;
    end
    vectors++;
    if (busy !== 1'b0 || req_ready !== 1'b1 || exp_q.size() != 0 || exp_ar_q.size() != 0) begin
      miscompares++;
      $display("FAIL desc_done: got busy %b req_ready %b pending %0d/%0d, required 0 1 0/0",
               busy, req_ready, exp_q.size(), exp_ar_q.size());
      exp_q.delete();
      exp_ar_q.delete();
    end
  endtask

  task automatic test_reset();
    drv_rst = 1'b1;
    step();
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_req_ready: got %b, required 0", req_ready);
    end
    drv_rst = 1'b0;
    step();
    vectors++;
    if ({req_ready, busy, err, axi.ar_valid} !== 4'b1000) begin
      miscompares++;
      $display("FAIL reset_state: got rdy/busy/err/arv %b%b%b%b, required 1000",
               req_ready, busy, err, axi.ar_valid);
    end
    vectors++;
    if ({axi.aw_valid, axi.w_valid, axi.b_ready} !== 3'b001) begin
      miscompares++;
      $display("FAIL tieoff: got aw/w/b %b%b%b, required 001", axi.aw_valid, axi.w_valid, axi.b_ready);
    end
    rq_addr.push_back(64'h0);
    rq_len.push_back(1);
    step();
    vectors++;
    if ({data_valid, axi.r_ready} !== 2'b00) begin
      miscompares++;
      $display("FAIL idle_gate: got data_valid %b r_ready %b, required 0 0", data_valid, axi.r_ready);
    end
    rq_addr.delete();
    rq_len.delete();
    r_idx = 0;
  endtask

  task automatic test_single();
    exp_ar_q.push_back({64'h1000, 8'd3});
    start_desc(64'h1000, 4);
    finish_desc();
  endtask

  task automatic test_4k_split();
    exp_ar_q.push_back({64'h0FF0, 8'd1});
    exp_ar_q.push_back({64'h1000, 8'd5});
    start_desc(64'h0FF0, 8);
    finish_desc();
  endtask

  task automatic test_maxburst_split();
    exp_ar_q.push_back({64'h0, 8'd15});
    exp_ar_q.push_back({64'h80, 8'd15});
    exp_ar_q.push_back({64'h100, 8'd7});
    start_desc(64'h0, 40);
    finish_desc();
  endtask

  task automatic test_outstanding();
    logic seen;
    seen = 1'b0;
    r_en = 1'b0;
    exp_ar_q.push_back({64'h0, 8'd15});
    exp_ar_q.push_back({64'h80, 8'd15});
    exp_ar_q.push_back({64'h100, 8'd15});
    start_desc(64'h0, 48);
    for (int i = 0; i < 20; i++) step();
    vectors++;
    if (ar_count != 2 || axi.ar_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL outstanding_cap: got %0d ARs ar_valid %b, required 2 ARs ar_valid 0",
               ar_count, axi.ar_valid);
    end
    r_en = 1'b1;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      seen = rlast_now;
    end
    step();
    vectors++;
    if (!seen || axi.ar_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL third_ar: got rlast_seen %b ar_valid %b, required 1 1", seen, axi.ar_valid);
    end
    finish_desc();
  endtask

  task automatic test_error();
    logic seen;
    seen = 1'b0;
    err_at = r_gbeat + 1;
    exp_ar_q.push_back({64'h2000, 8'd3});
    start_desc(64'h2000, 4);
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      seen = errbeat_now;
    end
    vectors++;
    if (!seen || err !== 1'b0) begin
      miscompares++;
      $display("FAIL err_before: got seen %b err %b, required 1 0", seen, err);
    end
    step();
    vectors++;
    if (err !== 1'b1) begin
      miscompares++;
      $display("FAIL err_set: got %b, required 1", err);
    end
    finish_desc();
    err_at = -1;
    step();
    vectors++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL err_sticky_idle: got err %b busy %b, required 1 0", err, busy);
    end
    start_desc(64'h2100, 0);
    vectors++;
    if (err !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL zero_beats: got err %b busy %b req_ready %b, required 0 0 1", err, busy, req_ready);
    end
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (ar_count != 0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_beats_quiet: got %0d ARs busy %b, required 0 0", ar_count, busy);
    end
  endtask

  task automatic test_backpressure();
    int base;
    push_model_ars(64'h4000, 16);
    start_desc(64'h4000, 16);
    base = data_count;
    for (int i = 0; i < 100 && data_count < base + 3; i++) step();
    dr_mode = 2;
    for (int i = 0; i < 10; i++) begin
      step();
      vectors++;
      if (axi.r_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL hold_r_ready: got %b, required 0", axi.r_ready);
      end
    end
    dr_mode = 0;
    finish_desc();
  endtask

  task automatic test_reset_drain();
    int base;
    err_at = r_gbeat;
    push_model_ars(64'h3000, 8);
    start_desc(64'h3000, 8);
    base = data_count;
    for (int i = 0; i < 100 && data_count < base + 2; i++) step();
    dr_mode = 2;
    for (int i = 0; i < 50 && dbg_state != 2'd2; i++) step();
    vectors++;
    if (err !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_pre: got err %b busy %b, required 1 1", err, busy);
    end
    drv_rst = 1'b1;
    step();
    drv_rst = 1'b0;
    dr_mode = 0;
    step();
    vectors++;
    if ({busy, axi.ar_valid, req_ready, err} !== 4'b0010) begin
      miscompares++;
      $display("FAIL drain_reset: got busy/arv/rdy/err %b%b%b%b, required 0010",
               busy, axi.ar_valid, req_ready, err);
    end
    vectors++;
    if (axi.r_valid !== 1'b1 || axi.r_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL late_r_sunk: got r_valid %b r_ready %b, required 1 0", axi.r_valid, axi.r_ready);
    end
    rq_addr.delete();
    rq_len.delete();
    r_idx = 0;
    err_at = -1;
    exp_q.delete();
    exp_ar_q.delete();
  endtask

  task automatic test_back_to_back();
    logic [63:0] a;
    int n;
    dr_mode = 1;
    ar_mode = 1;
    for (int k = 0; k < 8; k++) begin
      a = 64'($urandom_range(0, 3)) * 64'd4096 + 64'($urandom_range(0, 511)) * 64'd8
          + 64'($urandom_range(0, 7));
      n = $urandom_range(1, 40);
      push_model_ars(a, n);
      start_desc(a, n);
      finish_desc();
    end
    dr_mode = 0;
    ar_mode = 0;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    req_beats = '0;
    data_ready = 1'b0;
    axi.aw_ready = 1'b0;
    axi.w_ready = 1'b0;
    axi.b_id = '0;
    axi.b_resp = '0;
    axi.b_user = '0;
    axi.b_valid = 1'b0;
    axi.ar_ready = 1'b0;
    axi.r_id = '0;
    axi.r_data = '0;
    axi.r_resp = '0;
    axi.r_last = 1'b0;
    axi.r_user = '0;
    axi.r_valid = 1'b0;
    test_reset();
    test_single();
    test_4k_split();
    test_maxburst_split();
    test_outstanding();
    test_error();
    test_backpressure();
    test_reset_drain();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
